rr_arbiter_hold: RTL

Parametrised N-way round-robin arbiter with grant tenure. A grantee keeps the grant for up to MAX_HOLD consecutive cycles while it keeps requesting, then the grant rotates to the next active requester. Requesters can be masked at run time. The block sits in front of shared resources (bus ports, memory banks) as the next-generation replacement for the fixed 4-channel, one-cycle-rotation arbiter.

---
 rtl/rr_arbiter_hold_if.sv | 15 +
 rtl/rr_arbiter_hold.sv | 68 ++++++
 2 files changed

// File: rtl/rr_arbiter_hold_if.sv
// rr_arbiter_hold_if: request/grant bundle between requesters (master) and the arbiter (slave)
// Ports: req/en_mask driven by master; gnt, gnt_vld, gnt_id, hold_cnt driven by slave
interface rr_arbiter_hold_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic [N-1:0]     en_mask;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_id;
    logic [7:0]       hold_cnt;
    modport master (output req, en_mask, input gnt, gnt_vld, gnt_id, hold_cnt);
    modport slave  (input req, en_mask, output gnt, gnt_vld, gnt_id, hold_cnt);
endinterface

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: N-way round-robin arbiter where a grantee keeps the grant up to MAX_HOLD cycles
// Ports: clk, rst_n (async, active-low); bus.req/bus.en_mask in; bus.gnt (one-hot),
//        bus.gnt_vld, bus.gnt_id (held when idle), bus.hold_cnt (tenure minus 1) out, all registered
module rr_arbiter_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input logic             clk,
    input logic             rst_n,
    rr_arbiter_hold_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, id_n, sel;
    logic [IDX_W:0]   idx;
    logic [7:0]       hold_n;
    logic [N-1:0]     ereq;
    logic             found;
    assign ereq = bus.req & bus.en_mask;
    // While granted, ptr is always owner+1, so one scan from ptr serves idle, release and timeout alike
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(N)) idx = idx - (IDX_W+1)'(N);
            if (!found && ereq[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDX_W-1:0];
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = bus.gnt_id;
        hold_n  = bus.hold_cnt;
        if (state == IDLE || !ereq[bus.gnt_id] || bus.hold_cnt == 8'(MAX_HOLD - 1)) begin
            state_n = found ? GRANT : IDLE;
            hold_n  = '0;
            if (found) begin
                id_n  = sel;
                ptr_n = (sel == IDX_W'(N - 1)) ? '0 : sel + 1'b1;
            end
        end else begin
            hold_n = bus.hold_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            bus.gnt      <= '0;
            bus.gnt_vld  <= 1'b0;
            bus.gnt_id   <= '0;
            bus.hold_cnt <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            bus.gnt      <= (state_n == GRANT) ? {{(N-1){1'b0}}, 1'b1} << id_n : '0;
            bus.gnt_vld  <= state_n == GRANT;
            bus.gnt_id   <= id_n;
            bus.hold_cnt <= hold_n;
        end
    end
endmodule
